universal_shift_register: RTL
=============================

# universal_shift_register

Parametrised N-bit register: the next generation of the team's parallel-load register. Adds synchronous enable, clear, serial shift in both directions, rotate, and arithmetic shift right. A shift counter raises a one-cycle `done` flag after every N shift operations, so the block can act directly as the serializer or deserializer stage of a link datapath.

## Interface
- `N`, default 8: register width in bits; legal range N ≥ 2.
- `CW`, default `$clog2(N+1)`: shift-counter width (derived localparam, not overridable).

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: operation enable; when 0 the block holds regardless of `mode`.
- `mode` input 3: operation select (encoding under Operation).
- `d` input N: parallel load data.
- `sin_l` input 1: serial bit entering the MSB on a right shift.
- `sin_r` input 1: serial bit entering the LSB on a left shift.
- `q` output N: register contents.
- `sout_r` output 1: equals `q[0]` (combinational from state).
- `sout_l` output 1: equals `q[N-1]` (combinational from state).
- `shift_cnt` output CW: shifts performed since the last load, clear, or wrap.
- `done` output 1: registered; high for one cycle after the Nth shift.

## Operation
Mode encoding. "Shift op" means modes 2–6.
- 0 HOLD: q unchanged.
- 1 LOAD: q ← d; cnt ← 0.
- 2 SHR: q ← {sin_l, q[N-1:1]}.
- 3 SHL: q ← {q[N-2:0], sin_r}.
- 4 ROR: q ← {q[0], q[N-1:1]}.
- 5 ROL: q ← {q[N-2:0], q[N-1]}.
- 6 ASR: q ← {q[N-1], q[N-1:1]}. Sign is preserved; `sin_l` is ignored.
- 7 CLR: q ← 0; cnt ← 0.

Enable and next-state rules:
- `en`=0: q, cnt hold; done ← 0.
- Next-state logic is combinational and separate from the state registers (current-state / next-state split).

Shift counter:
- Each enabled shift op increments cnt.
- If the increment would reach N, cnt ← 0 and done ← 1 on that same edge. Otherwise done ← 0.
- LOAD, CLR, HOLD: done ← 0.
- Rotates and ASR count exactly like logical shifts.

Reset:
- Asserting `rst` at any time, including mid-sequence, immediately forces q=0, cnt=0, done=0 without waiting for a clock edge.
- On the first rising edge after `rst` deasserts, normal operation resumes with the inputs present at that edge.

## Timing
- Latency: one cycle. Inputs sampled at edge k appear on `q`/`shift_cnt`/`done` after edge k.
- `sout_l`/`sout_r` track `q` with zero added latency.
- `done` is high for exactly one cycle per N shift ops. Shift ops on consecutive cycles give `done` high after edges N, 2N, 3N, …
- Gaps with `en`=0 or HOLD stretch the period but do not reset the count.
- LOAD on the cycle after the Nth shift is legal. `done` is still high during that cycle (it was set by the previous edge); cnt restarts at 0.
- No combinational path exists from any input to `q`, `shift_cnt` or `done`.

## Structure
- Shared package `shift_reg_pkg`: 3-bit mode encoding constants (`MODE_HOLD` … `MODE_CLR`).
- Sub-module `shift_counter`: modulo-N counter with increment and clear inputs, plus the registered `done` pulse. Instantiated once.
- The top level contains the next-state mux and the q register.

## Test plan
All scenarios use N=8.
- Async reset: load 0x5A, then pulse `rst` between clock edges → q=0x00, shift_cnt=0, done=0 immediately, before the next edge.
- Logical shifts: LOAD 0xA5; SHR with sin_l=1 → 0xD2; then SHL with sin_r=0 → 0xA4. Check sout_l=1 and sout_r=0 at 0xA4.
- Rotate/arith: LOAD 0x81; ROR → 0xC0. Separately, 0x81 ROL → 0x03. LOAD 0x80 then ASR ×7 → 0xFF. LOAD 0x40 then ASR → 0x20.
- Counter/done: LOAD 0x00, then 8 consecutive SHR with sin_l=1 → q=0xFF. done=1 only in the cycle after the 8th edge; shift_cnt=0 then.
- Enable/gaps: 4 SHL, then 3 cycles with en=0 and mode=LOAD, d=0xFF → q and shift_cnt=4 unchanged. Then 4 more SHL → done after the 8th shift.
- Clear mid-count: 5 SHR, then CLR → q=0, shift_cnt=0, no done pulse. A further 8 shifts → exactly one done pulse.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: operation encodings shared by the universal shift register and its bench.
package shift_reg_pkg;
  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHR  = 3'd2;
  localparam logic [2:0] MODE_SHL  = 3'd3;
  localparam logic [2:0] MODE_ROR  = 3'd4;
  localparam logic [2:0] MODE_ROL  = 3'd5;
  localparam logic [2:0] MODE_ASR  = 3'd6;
  localparam logic [2:0] MODE_CLR  = 3'd7;
endpackage

// File: rtl/shift_counter.sv
// shift_counter: modulo-N shift counter with a registered one-cycle done pulse on wrap.
module shift_counter #(
  parameter int N = 8,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          done
);
  logic wrap;
  assign wrap = inc && (cnt == CW'(N - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      cnt  <= clr ? '0 : inc ? (wrap ? '0 : cnt + CW'(1)) : cnt;
      done <= wrap;
    end
  end
endmodule

// File: rtl/universal_shift_register.sv
// universal_shift_register: N-bit load/shift/rotate/arith-shift register with shift counter and done pulse.
module universal_shift_register
  import shift_reg_pkg::*;
#(
  parameter int N = 8,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic [N-1:0]  d,
  input  logic          sin_l,
  input  logic          sin_r,
  output logic [N-1:0]  q,
  output logic          sout_r,
  output logic          sout_l,
  output logic [CW-1:0] shift_cnt,
  output logic          done
);
  logic [N-1:0] q_nxt;
  logic         shift_op;
  assign shift_op = (mode >= MODE_SHR) && (mode <= MODE_ASR);
  assign sout_r   = q[0];
  assign sout_l   = q[N-1];
  always_comb begin
    q_nxt = q;
    if (en) begin
      case (mode)
        MODE_LOAD: q_nxt = d;
        MODE_SHR:  q_nxt = {sin_l, q[N-1:1]};
        MODE_SHL:  q_nxt = {q[N-2:0], sin_r};
        MODE_ROR:  q_nxt = {q[0], q[N-1:1]};
        MODE_ROL:  q_nxt = {q[N-2:0], q[N-1]};
        MODE_ASR:  q_nxt = {q[N-1], q[N-1:1]};
        MODE_CLR:  q_nxt = '0;
        default:   q_nxt = q;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= q_nxt;
  end
  shift_counter #(.N(N)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (en && shift_op),
    .clr  (en && (mode == MODE_LOAD || mode == MODE_CLR)),
    .cnt  (shift_cnt),
    .done (done)
  );
endmodule
